// File: rtl/imem_loader.sv
// Byte-stream programmer for the CPU instruction memory: assembles big-endian words,
// writes them to consecutive imem addresses and holds the CPU in reset until loading finishes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte after the last word).
module imem_loader #(
    parameter int DEPTH_LOG2 = 8,
    parameter int ADDR_LEN   = 32,
    parameter int INSTR_LEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DEPTH_LOG2:0]   word_count,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_LEN-1:0]   imem_addr,
    output logic [INSTR_LEN-1:0]  imem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [DEPTH_LOG2:0] MAX_WORDS = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK   = 3'd3,
`endif
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t                 state, state_n;
    logic [DEPTH_LOG2:0]    word_idx, word_idx_n;
    logic [DEPTH_LOG2:0]    wc, wc_n;
    logic [1:0]             byte_idx, byte_idx_n;
    logic [INSTR_LEN-1:0]   shift, shift_n;
    logic                   in_ready_n, imem_we_n, cpu_rst_n, busy_n, done_n, error_n;
    logic [ADDR_LEN-1:0]    imem_addr_n;
    logic [INSTR_LEN-1:0]   imem_wdata_n;
    logic                   hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             xor_acc, xor_acc_n;
`endif

    assign hs = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_idx   <= '0;
            wc         <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc    <= '0;
`endif
        end else begin
            state      <= state_n;
            word_idx   <= word_idx_n;
            wc         <= wc_n;
            byte_idx   <= byte_idx_n;
            shift      <= shift_n;
            in_ready   <= in_ready_n;
            imem_we    <= imem_we_n;
            imem_addr  <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            cpu_rst    <= cpu_rst_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc    <= xor_acc_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        word_idx_n   = word_idx;
        wc_n         = wc;
        byte_idx_n   = byte_idx;
        shift_n      = shift;
        in_ready_n   = in_ready;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        cpu_rst_n    = cpu_rst;
        busy_n       = busy;
        done_n       = done;
        error_n      = error;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_acc_n    = xor_acc;
`endif

        case (state)
            // Start is only honoured when no load is in flight.
            IDLE, DONE, ERR: begin
                if (start) begin
                    wc_n       = word_count;
                    word_idx_n = '0;
                    byte_idx_n = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_acc_n  = '0;
`endif
                    if (word_count == '0) begin
                        state_n   = DONE;
                        cpu_rst_n = 1'b0;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        error_n   = 1'b0;
                    end else if (word_count > MAX_WORDS) begin
                        state_n   = ERR;
                        cpu_rst_n = 1'b1;
                        done_n    = 1'b0;
                        busy_n    = 1'b0;
                        error_n   = 1'b1;
                    end else begin
                        state_n    = RECV;
                        cpu_rst_n  = 1'b1;
                        done_n     = 1'b0;
                        busy_n     = 1'b1;
                        error_n    = 1'b0;
                        in_ready_n = 1'b1;
                    end
                end
            end

            RECV: begin
                if (hs) begin
                    shift_n = {shift[INSTR_LEN-9:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_acc_n = xor_acc ^ in_data;
`endif
                    if (byte_idx == 2'd3) begin
                        // Write enable is registered with the WRITE state so it lasts exactly that cycle.
                        state_n      = WRITE;
                        byte_idx_n   = '0;
                        in_ready_n   = 1'b0;
                        imem_we_n    = 1'b1;
                        imem_addr_n  = {{(ADDR_LEN-DEPTH_LOG2-1){1'b0}}, word_idx} << 2;
                        imem_wdata_n = {shift[INSTR_LEN-9:0], in_data};
                    end else begin
                        byte_idx_n = byte_idx + 2'd1;
                    end
                end
            end

            WRITE: begin
                if (word_idx == wc - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_n    = CHK;
                    in_ready_n = 1'b1;
`else
                    state_n   = DONE;
                    cpu_rst_n = 1'b0;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
`endif
                end else begin
                    word_idx_n = word_idx + 1'b1;
                    state_n    = RECV;
                    in_ready_n = 1'b1;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (hs) begin
                    in_ready_n = 1'b0;
                    busy_n     = 1'b0;
                    if (in_data == xor_acc) begin
                        state_n   = DONE;
                        cpu_rst_n = 1'b0;
                        done_n    = 1'b1;
                    end else begin
                        state_n   = ERR;
                        cpu_rst_n = 1'b1;
                        error_n   = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_n    = IDLE;
                in_ready_n = 1'b0;
                cpu_rst_n  = 1'b1;
                busy_n     = 1'b0;
            end
        endcase
    end

endmodule
